// File: rtl/jt49_noise_pkg.sv
// Shared constants for the JT49 noise generator: mode encodings and default polynomials.
// Latency: none (package only).
// Backpressure: none (package only).
package jt49_noise_pkg;

  localparam logic NOISE_LONG  = 1'b0;
  localparam logic NOISE_SHORT = 1'b1;

  // Long mode defaults to x^17+x^14+1 and short mode to x^7+x^6+1.
  localparam int DEF_LFSR_W    = 17;
  localparam int DEF_LONG_TAP  = 3;
  localparam int DEF_SHORT_W   = 7;
  localparam int DEF_SHORT_TAP = 1;

endpackage

// File: rtl/jt49_noise_cnt.sv
// Period counter: raises tick on the cen cycle that ends each period (period 0 acts as 1).
// Latency: tick is combinational on the terminal cen cycle; cnt clears on that edge.
// Backpressure: none; cen low freezes the count and clr clears it regardless of cen.
module jt49_noise_cnt
  import jt49_noise_pkg::*;
#(
  parameter int PERIOD_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] lim;
  logic                at_end;

  // Terminal count is period-1, with period 0 folded onto 1. The >= compare
  // means lowering period below the current count ends the period at once.
  assign lim    = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign at_end = (cnt >= lim);
  assign tick   = cen && at_end;

  // Count cen pulses; wrap to 0 at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cen) begin
      if (at_end) cnt <= '0;
      else        cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/jt49_noise_gen.sv
// Noise generator: LFSR stepped by the period counter, long or short polynomial (JT49_NOISE_SHORT_EN).
// Latency: lfsr/noise/step update on the edge closing the terminal cen cycle; step lasts one cycle.
// Backpressure: none; cen low freezes state, restart clears counter and LFSR regardless of cen.
module jt49_noise_gen
  import jt49_noise_pkg::*;
#(
  parameter int PERIOD_W  = 5,
  parameter int LFSR_W    = DEF_LFSR_W,
  parameter int LONG_TAP  = DEF_LONG_TAP,
  parameter int SHORT_W   = DEF_SHORT_W,
  parameter int SHORT_TAP = DEF_SHORT_TAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic [PERIOD_W-1:0] period,
  input  logic                mode,
  input  logic                restart,
  output logic                noise,
  output logic                step
);

  logic              tick;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic              z;

  jt49_noise_cnt #(
    .PERIOD_W (PERIOD_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .clr    (restart),
    .period (period),
    .tick   (tick)
  );

`ifdef JT49_NOISE_SHORT_EN
  logic zs;

  // Next LFSR value: full-length shift, or shift of the low window only.
  // The zero terms pull the register out of the all-zero state.
  always_comb begin
    z        = (lfsr == '0);
    zs       = (lfsr[SHORT_W-1:0] == '0);
    lfsr_nxt = {lfsr[0] ^ lfsr[LONG_TAP] ^ z, lfsr[LFSR_W-1:1]};
    if (mode == NOISE_SHORT) begin
      lfsr_nxt                = lfsr;
      lfsr_nxt[SHORT_W-1:0]   = {lfsr[0] ^ lfsr[SHORT_TAP] ^ zs, lfsr[SHORT_W-1:1]};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode ^ (SHORT_W > SHORT_TAP);

  // Next LFSR value: long polynomial only; the zero term escapes lock-up.
  always_comb begin
    z        = (lfsr == '0);
    lfsr_nxt = {lfsr[0] ^ lfsr[LONG_TAP] ^ z, lfsr[LFSR_W-1:1]};
  end
`endif

  // LFSR and step strobe; a tick coinciding with restart is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= '0;
      step <= 1'b0;
    end else if (restart) begin
      lfsr <= '0;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) lfsr <= lfsr_nxt;
    end
  end

  assign noise = lfsr[0];

endmodule
